rr_onehot_grant: RTL

- Four-requester round-robin grant generator; the producing end of the zero-or-one-hot 4-line interface.
- Drives four scalar grant lines that, by construction, are all-zero or exactly one-hot at every cycle.
- Downstream one-hot validity checkers sit directly on its grant outputs.
- Adds a release handshake and a hold timeout so a stuck owner cannot starve the other requesters.

---
 rtl/rr_onehot_grant_pkg.sv | 18 +
 rtl/rr_onehot_grant_if.sv | 28 ++
 rtl/rr_pick.sv | 26 ++
 rtl/rr_onehot_grant.sv | 79 +++++++
 4 files changed

// File: rtl/rr_onehot_grant_pkg.sv
// Shared constants and types for the four-requester round-robin grant generator.
package rr_onehot_grant_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Requester indices as carried on gnt_id
    localparam logic [IDX_W-1:0] REQ1_IDX = 2'd0;
    localparam logic [IDX_W-1:0] REQ2_IDX = 2'd1;
    localparam logic [IDX_W-1:0] REQ3_IDX = 2'd2;
    localparam logic [IDX_W-1:0] REQ4_IDX = 2'd3;

endpackage

// File: rtl/rr_onehot_grant_if.sv
// Zero-or-one-hot four-line grant interface; master is the granting end.
interface rr_onehot_grant_if;
    import rr_onehot_grant_pkg::*;

    logic             req1;
    logic             req2;
    logic             req3;
    logic             req4;
    logic             done;
    logic             gnt1;
    logic             gnt2;
    logic             gnt3;
    logic             gnt4;
    logic [IDX_W-1:0] gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        input  req1, req2, req3, req4, done,
        output gnt1, gnt2, gnt3, gnt4, gnt_id, busy, timeout
    );

    modport slave (
        output req1, req2, req3, req4, done,
        input  gnt1, gnt2, gnt3, gnt4, gnt_id, busy, timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set req bit scanning ptr, ptr+1, ... mod NUM_REQ.
module rr_pick
    import rr_onehot_grant_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] k;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        k     = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/rr_onehot_grant.sv
// Round-robin grant generator with done-release handshake and hold timeout.
module rr_onehot_grant
    import rr_onehot_grant_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_onehot_grant_if.master  bus
);

    state_t               state;
    logic [NUM_REQ-1:0]   req_c;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]     gnt_id_q;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     cnt;
    logic                 busy_q;
    logic                 timeout_q;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;

    assign req_c = {bus.req4, bus.req3, bus.req2, bus.req1};

    rr_pick u_pick (
        .req   (req_c),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant FSM; grant lines only ever load a single shifted bit or zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= REQ1_IDX;
            ptr       <= REQ1_IDX;
            cnt       <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        gnt_q    <= NUM_REQ'(1) << pick_idx;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        cnt      <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (bus.done || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr       <= gnt_id_q + IDX_W'(1);
                        timeout_q <= !bus.done;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt1    = gnt_q[0];
    assign bus.gnt2    = gnt_q[1];
    assign bus.gnt3    = gnt_q[2];
    assign bus.gnt4    = gnt_q[3];
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule
